// File: rtl/rob_resp_merge.sv
// rob_resp_merge: buffers out-of-order bank read responses and releases them per channel in keep-order issue order
module rob_resp_merge #(
    parameter int DATA_W     = 32,
    parameter int RESP_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                d_ch_0_rob_req,
    input  logic [1:0]          d_ch_0_rob_bank_id,
    output logic                d_ch_0_rob_ack,
    input  logic                d_ch_1_rob_req,
    input  logic [1:0]          d_ch_1_rob_bank_id,
    output logic                d_ch_1_rob_ack,
    input  logic                d_ch_2_rob_req,
    input  logic [1:0]          d_ch_2_rob_bank_id,
    output logic                d_ch_2_rob_ack,
    input  logic [3:0]          bank_resp_valid,
    input  logic [7:0]          bank_resp_ch_id,
    input  logic [4*DATA_W-1:0] bank_resp_data,
    output logic [3:0]          bank_resp_ready,
    output logic                u_channel_0_resp_valid,
    output logic [DATA_W-1:0]   u_channel_0_resp_data,
    input  logic                u_channel_0_resp_ready,
    output logic                u_channel_1_resp_valid,
    output logic [DATA_W-1:0]   u_channel_1_resp_data,
    input  logic                u_channel_1_resp_ready,
    output logic                u_channel_2_resp_valid,
    output logic [DATA_W-1:0]   u_channel_2_resp_data,
    input  logic                u_channel_2_resp_ready
);
    localparam int AW = $clog2(RESP_DEPTH);
    localparam int PW = AW + 1;

    // FIFO index is {channel, bank}; slots 12..15 (channel 3) are permanently empty and never full
    logic [15:0]       full;
    logic [15:0]       empty;
    logic [DATA_W-1:0] head [16];

    logic [2:0]        rob_req;
    logic [1:0]        rob_bank [3];
    logic [2:0]        rob_ack;
    logic [2:0]        resp_ready;
    logic [2:0]        resp_valid;
    logic [DATA_W-1:0] resp_data [3];

    assign rob_req     = {d_ch_2_rob_req, d_ch_1_rob_req, d_ch_0_rob_req};
    assign rob_bank[0] = d_ch_0_rob_bank_id;
    assign rob_bank[1] = d_ch_1_rob_bank_id;
    assign rob_bank[2] = d_ch_2_rob_bank_id;
    assign resp_ready  = {u_channel_2_resp_ready, u_channel_1_resp_ready, u_channel_0_resp_ready};

    assign d_ch_0_rob_ack         = rob_ack[0];
    assign d_ch_1_rob_ack         = rob_ack[1];
    assign d_ch_2_rob_ack         = rob_ack[2];
    assign u_channel_0_resp_valid = resp_valid[0];
    assign u_channel_1_resp_valid = resp_valid[1];
    assign u_channel_2_resp_valid = resp_valid[2];
    assign u_channel_0_resp_data  = resp_data[0];
    assign u_channel_1_resp_data  = resp_data[1];
    assign u_channel_2_resp_data  = resp_data[2];

    assign full[15:12]  = '0;
    assign empty[15:12] = '1;
    for (genvar i = 12; i < 16; i++) begin : g_pad
        assign head[i] = '0;
    end

    for (genvar c = 0; c < 3; c++) begin : g_ch
        for (genvar b = 0; b < 4; b++) begin : g_bank
            logic [DATA_W-1:0] mem [RESP_DEPTH];
            logic [PW-1:0]     wp;
            logic [PW-1:0]     rp;
            logic              push;
            logic              pop;

            assign full[c*4+b]  = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
            assign empty[c*4+b] = (wp == rp);
            assign head[c*4+b]  = mem[rp[AW-1:0]];
            assign push = bank_resp_valid[b] && (bank_resp_ch_id[2*b+:2] == 2'(c)) && !full[c*4+b];
            assign pop  = rob_ack[c] && (rob_bank[c] == 2'(b));

            // Advance write/read pointers; push and pop may coincide
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    wp <= '0;
                    rp <= '0;
                end else begin
                    if (push) wp <= wp + PW'(1);
                    if (pop) rp <= rp + PW'(1);
                end
            end

            // Storage holds no reset; validity is tracked by the pointers alone
            always_ff @(posedge clk) begin
                if (push) mem[wp[AW-1:0]] <= bank_resp_data[b*DATA_W+:DATA_W];
            end
        end

        assign rob_ack[c] = rob_req[c] && !empty[{2'(c), rob_bank[c]}] && (!resp_valid[c] || resp_ready[c]);

        // Output register: load popped head on ack, otherwise clear once accepted upstream
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                resp_valid[c] <= 1'b0;
                resp_data[c]  <= '0;
            end else if (rob_ack[c]) begin
                resp_valid[c] <= 1'b1;
                resp_data[c]  <= head[{2'(c), rob_bank[c]}];
            end else if (resp_ready[c]) begin
                resp_valid[c] <= 1'b0;
            end
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_ready
        // Channel 3 maps onto a never-full slot, so illegal responses are accepted and dropped
        assign bank_resp_ready[b] = !full[{bank_resp_ch_id[2*b+:2], 2'(b)}];

        a_legal_ch : assert property (@(posedge clk) disable iff (!rstn)
            !(bank_resp_valid[b] && bank_resp_ch_id[2*b+:2] == 2'd3));
    end
endmodule

// File: tb/tb_rob_resp_merge.sv
// tb_rob_resp_merge: directed self-checking bench for rob_resp_merge
module tb_rob_resp_merge;
    logic         clk = 1'b0;
    logic         rstn;
    logic         req0, req1, req2;
    logic [1:0]   bid0, bid1, bid2;
    logic         ack0, ack1, ack2;
    logic [3:0]   bvalid;
    logic [7:0]   bch;
    logic [127:0] bdata;
    logic [3:0]   bready;
    logic         v0, v1, v2;
    logic [31:0]  d0, d1, d2;
    logic         r0, r1, r2;
    int           errors = 0;
    int           checks = 0;
    int           ack2_cnt = 0;

    rob_resp_merge #(.DATA_W(32), .RESP_DEPTH(2)) dut (
        .clk(clk), .rstn(rstn),
        .d_ch_0_rob_req(req0), .d_ch_0_rob_bank_id(bid0), .d_ch_0_rob_ack(ack0),
        .d_ch_1_rob_req(req1), .d_ch_1_rob_bank_id(bid1), .d_ch_1_rob_ack(ack1),
        .d_ch_2_rob_req(req2), .d_ch_2_rob_bank_id(bid2), .d_ch_2_rob_ack(ack2),
        .bank_resp_valid(bvalid), .bank_resp_ch_id(bch), .bank_resp_data(bdata),
        .bank_resp_ready(bready),
        .u_channel_0_resp_valid(v0), .u_channel_0_resp_data(d0), .u_channel_0_resp_ready(r0),
        .u_channel_1_resp_valid(v1), .u_channel_1_resp_data(d1), .u_channel_1_resp_ready(r1),
        .u_channel_2_resp_valid(v2), .u_channel_2_resp_data(d2), .u_channel_2_resp_ready(r2)
    );

    always #5 clk = ~clk;

    // Count ch2 acks mid-cycle, well away from the edge where resp_valid updates
    always @(negedge clk) if (rstn && ack2) ack2_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bank(input int b, input logic [1:0] ch, input logic [31:0] data);
        bvalid[b]        = 1'b1;
        bch[2*b+:2]      = ch;
        bdata[b*32+:32]  = data;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (v0 !== 1'b0 || v1 !== 1'b0 || v2 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b%b%b want 000", v2, v1, v0); end
        checks++; if (d0 !== 32'h0 || d1 !== 32'h0 || d2 !== 32'h0) begin errors++; $display("FAIL reset_data got %h %h %h want 0", d0, d1, d2); end
        checks++; if (bready !== 4'hF) begin errors++; $display("FAIL reset_ready got %h want f", bready); end
        tick();
        rstn = 1'b1;
        tick();
        checks++; if ({ack2, ack1, ack0} !== 3'b000) begin errors++; $display("FAIL reset_ack got %b want 000", {ack2, ack1, ack0}); end
    endtask

    task automatic test_basic();
        req0 = 1'b1; bid0 = 2'd2;
        bank(2, 2'd0, 32'hA5A5_0001);
        #1;
        checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL basic_no_flow_through got %b want 0", ack0); end
        tick();
        bvalid = '0;
        #1;
        checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL basic_ack got %b want 1", ack0); end
        tick();
        req0 = 1'b0;
        checks++; if (v0 !== 1'b1 || d0 !== 32'hA5A5_0001) begin errors++; $display("FAIL basic_resp got v=%b d=%h want v=1 d=a5a50001", v0, d0); end
        tick();
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL basic_valid_clear got %b want 0", v0); end
    endtask

    task automatic test_reorder();
        int early;
        early = 0;
        req1 = 1'b1; bid1 = 2'd3;
        bank(0, 2'd1, 32'h11);
        tick();
        bvalid = '0;
        for (int i = 0; i < 2; i++) begin
            #1; if (ack1) early++;
            tick();
        end
        bank(3, 2'd1, 32'h33);
        #1; if (ack1) early++;
        checks++; if (early != 0) begin errors++; $display("FAIL reorder_early_ack got %0d acks want 0", early); end
        tick();
        bvalid = '0;
        #1;
        checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL reorder_ack_t4 got %b want 1", ack1); end
        tick();
        bid1 = 2'd0;
        #1;
        checks++; if (v1 !== 1'b1 || d1 !== 32'h33) begin errors++; $display("FAIL reorder_first got v=%b d=%h want v=1 d=33", v1, d1); end
        checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL reorder_second_ack got %b want 1", ack1); end
        tick();
        req1 = 1'b0;
        checks++; if (v1 !== 1'b1 || d1 !== 32'h11) begin errors++; $display("FAIL reorder_second got v=%b d=%h want v=1 d=11", v1, d1); end
        tick();
    endtask

    task automatic test_backpressure();
        int base;
        r2 = 1'b0;
        bank(1, 2'd2, 32'h5);
        tick();
        bank(1, 2'd2, 32'h6);
        tick();
        bvalid = '0;
        base = ack2_cnt;
        req2 = 1'b1; bid2 = 2'd1;
        tick();
        tick();
        tick();
        tick();
        checks++; if (v2 !== 1'b1 || d2 !== 32'h5) begin errors++; $display("FAIL bp_hold got v=%b d=%h want v=1 d=5", v2, d2); end
        checks++; if (ack2_cnt - base != 1) begin errors++; $display("FAIL bp_one_ack got %0d want 1", ack2_cnt - base); end
        r2 = 1'b1;
        #1;
        checks++; if (ack2 !== 1'b1) begin errors++; $display("FAIL bp_release_ack got %b want 1", ack2); end
        tick();
        req2 = 1'b0;
        checks++; if (v2 !== 1'b1 || d2 !== 32'h6) begin errors++; $display("FAIL bp_second got v=%b d=%h want v=1 d=6", v2, d2); end
        checks++; if (ack2_cnt - base != 2) begin errors++; $display("FAIL bp_two_acks got %0d want 2", ack2_cnt - base); end
        tick();
    endtask

    task automatic test_full();
        bank(1, 2'd0, 32'h1);
        tick();
        bank(1, 2'd0, 32'h2);
        tick();
        bank(1, 2'd0, 32'h3);
        #1;
        checks++; if (bready[1] !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", bready[1]); end
        checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL full_no_req_ack got %b want 0", ack0); end
        bch[3:2] = 2'd2;
        #1;
        checks++; if (bready[1] !== 1'b1) begin errors++; $display("FAIL full_other_ch_ready got %b want 1", bready[1]); end
        bch[3:2] = 2'd0;
        req0 = 1'b1; bid0 = 2'd1;
        #1;
        checks++; if (bready[1] !== 1'b0 || ack0 !== 1'b1) begin errors++; $display("FAIL full_pop_no_passthru got ready=%b ack=%b want 0 1", bready[1], ack0); end
        bvalid = '0;
        tick();
        checks++; if (d0 !== 32'h1) begin errors++; $display("FAIL full_drain1 got %h want 1", d0); end
        tick();
        req0 = 1'b0;
        checks++; if (d0 !== 32'h2) begin errors++; $display("FAIL full_drain2 got %h want 2", d0); end
        tick();
    endtask

    task automatic test_simultaneous();
        logic [31:0] exp;
        for (int b = 0; b < 4; b++) bank(b, 2'd0, 32'hB0 + 32'(b));
        tick();
        bvalid = '0;
        req0 = 1'b1; bid0 = 2'd3;
        for (int k = 3; k >= 0; k--) begin
            tick();
            exp = 32'hB0 + 32'(k);
            if (k > 0) bid0 = 2'(k - 1); else req0 = 1'b0;
            checks++; if (v0 !== 1'b1 || d0 !== exp) begin errors++; $display("FAIL simul_bank%0d got v=%b d=%h want v=1 d=%h", k, v0, d0, exp); end
        end
        tick();
    endtask

    task automatic test_async_reset();
        bank(2, 2'd1, 32'h77);
        tick();
        bank(2, 2'd1, 32'h78);
        tick();
        bvalid = '0;
        req1 = 1'b1; bid1 = 2'd2;
        tick();
        #3;
        rstn = 1'b0;
        #1;
        checks++; if (v1 !== 1'b0 || d1 !== 32'h0 || ack1 !== 1'b0) begin errors++; $display("FAIL areset_immediate got v=%b d=%h ack=%b want 0 0 0", v1, d1, ack1); end
        tick();
        rstn = 1'b1;
        tick();
        #1;
        checks++; if (ack1 !== 1'b0 || v1 !== 1'b0) begin errors++; $display("FAIL areset_stale_req got ack=%b v=%b want 0 0", ack1, v1); end
        checks++; if (bready !== 4'hF) begin errors++; $display("FAIL areset_ready got %h want f", bready); end
        req1 = 1'b0;
        tick();
    endtask

    initial begin
        rstn = 1'b0;
        {req0, req1, req2} = '0;
        {bid0, bid1, bid2} = '0;
        bvalid = '0; bch = '0; bdata = '0;
        {r0, r1, r2} = 3'b111;
        test_reset();
        test_basic();
        test_reorder();
        test_backpressure();
        test_full();
        test_simultaneous();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
